store_buffer: RTL

Posted-write buffer between the one-cycle MIPS core's data-memory store port (`we_mem_out`, `data_addr`, `write_data`) and a slower memory bus. It accepts core stores in one cycle, queues them in a DEPTH-entry FIFO and drains them in order over a valid/ready handshake. It stalls the core when full and forwards buffered store data to same-address loads, so loads always see the newest stored value.

---
 rtl/store_buffer.sv | 97 +++++++++
 1 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with in-order bus drain and load forwarding
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_mem_out,
  input  logic [DATA_W-1:0]            data_addr,
  input  logic [DATA_W-1:0]            write_data,
  output logic                         stall,
  input  logic [DATA_W-1:0]            rd_addr,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data,
  output logic                         bus_valid,
  output logic [DATA_W-1:0]            bus_addr,
  output logic [DATA_W-1:0]            bus_data,
  input  logic                         bus_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;
  logic [PW-1:0]     fwd_idx;

  assign stall     = (count_q == FULL);
  assign bus_valid = (count_q != '0);
  assign bus_addr  = addr_q[rp_q];
  assign bus_data  = data_q[rp_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

  assign push = we_mem_out && !stall;
  assign pop  = bus_valid && bus_ready;

  always_comb begin
    wp_d    = push ? wp_q + 1'b1 : wp_q;
    rp_d    = pop  ? rp_q + 1'b1 : rp_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      // a push never targets the popped slot: full blocks push, empty blocks pop
      if (pop) begin
        valid_q[rp_q] <= 1'b0;
      end
      if (push) begin
        addr_q[wp_q]  <= data_addr;
        data_q[wp_q]  <= write_data;
        valid_q[wp_q] <= 1'b1;
      end
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // walk oldest to youngest so the last match left standing is the newest store
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rp_q;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rp_q + PW'(k);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx][DATA_W-1:2] == rd_addr[DATA_W-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

endmodule
